polaris_ibus_bridge: RTL and testbench
======================================

# polaris_ibus_bridge

Instruction-fetch bridge between the Polaris CPU's I-master port (iadr/isiz request, iack/idat response) and the 16-bit external program-memory bus. Each 32-bit fetch becomes two little-endian half-word beats with slave-paced wait states. A watchdog bounds each beat. Misaligned fetches, unsupported sizes and bus timeouts complete with an all-zero instruction word, which is guaranteed illegal, so the CPU jams instead of hanging.

## Interface
- TIMEOUT, default 16: maximum cycles a beat may wait for m_ack_i, range 2..255.
- clk_i  in  1  system clock; all registers update on its rising edge.
- reset_i  in  1  reset, asynchronous and active-high.
- iadr_i  in  64  fetch address from the CPU.
- isiz_i  in  2  fetch size from the CPU: 00 no request, 01 half-word, 10 word, 11 reserved.
- iack_o  out  1  one-cycle completion strobe to the CPU.
- idat_o  out  32  fetched instruction; valid only while iack_o=1, otherwise 0.
- m_cyc_o  out  1  bus cycle in progress.
- m_stb_o  out  1  beat strobe.
- m_adr_o  out  64  beat address, always even.
- m_dat_i  in  16  beat read data.
- m_ack_i  in  1  beat acknowledge; may be asserted in the same cycle as m_stb_o.
- err_o  out  1  one-cycle error pulse, coincident with iack_o.

## Operation
- Reset values: state=IDLE. iack_o, idat_o, m_cyc_o, m_stb_o, m_adr_o and err_o are all 0.
- All outputs are registered.
- States: IDLE, BEAT0, BEAT1, ACK.
- IDLE:
  - isiz_i=00: stay in IDLE.
  - isiz_i=10 with iadr_i[1:0]=00, or isiz_i=01 with iadr_i[0]=0: latch the address and go to BEAT0. Drive m_cyc_o=m_stb_o=1 and m_adr_o=latched address.
  - Misaligned address or isiz_i=11: go directly to ACK with idat=0 and err=1. No bus cycle.
- BEAT0:
  - m_ack_i=1: capture m_dat_i into lo.
  - Word fetch: go to BEAT1 with m_adr_o=address+2. m_stb_o stays high.
  - Half-word fetch: go to ACK with idat={16'h0, lo}.
- BEAT1: on m_ack_i=1, capture hi and go to ACK with idat={hi, lo}.
- Watchdog:
  - Counts cycles spent in BEAT0/BEAT1 without m_ack_i and clears at every beat entry.
  - When the count reaches TIMEOUT-1 with m_ack_i still low, the next state is ACK with idat=0 and err=1.
  - m_cyc_o and m_stb_o drop at that edge.
- ACK:
  - iack_o=1 for exactly one cycle, with err_o as latched. m_cyc_o=m_stb_o=0.
  - isiz_i is ignored during ACK. The next state is IDLE unconditionally.
- Changes to isiz_i or iadr_i after a request is accepted are ignored; the latched transaction runs to completion.
- Address arithmetic is modulo 2^64: FFFF_FFFF_FFFF_FFFE+2 wraps to 0 for the high beat.
- m_ack_i arriving in IDLE or ACK is ignored.

## Timing
- Request sampled at edge E0.
- Zero-wait-state word fetch:
  - m_stb_o high in cycles E0..E2, m_adr_o=A, then A+2.
  - iack_o high in cycle E2..E3.
  - Latency is 3 cycles, edge to iack.
- Zero-wait-state half-word fetch: iack_o high in cycle E1..E2.
- Each wait state adds one cycle per beat.
- Misaligned or reserved-size fetch: iack_o high in cycle E0..E1.
- Timeout: iack_o rises TIMEOUT cycles after the stalled beat began.
- Minimum request-to-request spacing is 1 IDLE cycle after ACK. The CPU must drop isiz_i at the edge where it samples iack_o.
- reset_i mid-transaction:
  - All outputs clear immediately (asynchronously), including m_cyc_o/m_stb_o.
  - The transaction is abandoned with no iack_o.
  - After release, the block is in IDLE.

## Structure
- Shared package polaris_pkg holds:
  - isiz codes: ISIZ_NONE, ISIZ_H, ISIZ_W, ISIZ_RSVD.
  - State encoding: IDLE, BEAT0, BEAT1, ACK.
  - Constant ILLEGAL_INSN = 32'h0000_0000.
- One sub-module, bus_watchdog:
  - Counter of width $clog2(TIMEOUT).
  - Inputs clear and count; output expired.
  - Same clock and reset as the bridge.

## Test plan
- Reset mid-BEAT1 (reset_i=1 asynchronously): m_cyc_o/m_stb_o fall without a clock edge, and iack_o never pulses. Fetch iadr=FFFF_FFFF_FFFF_FF00, isiz=10, zero-wait slave returning 0013 at FF00 and 0000 at FF02: m_adr_o sequence FF00 then FF02, iack_o one cycle, idat_o=0000_0013, err_o=0.
- Same fetch with the slave inserting 2 wait states on each beat: iack_o arrives exactly 4 cycles later than the zero-wait case, and data is unchanged.
- isiz=01 at address 0000_0000_0000_0102 with the slave returning ABCD: single beat, idat_o=0000_ABCD.
- iadr=...0102 with isiz=10, and separately isiz=11 at an aligned address: no m_stb_o, iack_o and err_o in the cycle after the request, idat_o=0.
- TIMEOUT=4 with a slave that never acks: m_stb_o high for 4 cycles, then drops; iack_o=err_o=1, idat_o=0; the next request is accepted after 1 IDLE cycle.
- Word fetch at FFFF_FFFF_FFFF_FFFC: beats at FFFC then FFFE. Half-word at FFFE: single beat, with no wrap needed.

Source files
------------

// File: rtl/polaris_pkg.sv
// Shared Polaris definitions: fetch-size codes, bridge state encoding, bus widths.
package polaris_pkg;

  localparam int unsigned ADR_W  = 64;
  localparam int unsigned DAT_W  = 32;
  localparam int unsigned BEAT_W = 16;

  typedef enum logic [1:0] {
    ISIZ_NONE = 2'b00,
    ISIZ_H    = 2'b01,
    ISIZ_W    = 2'b10,
    ISIZ_RSVD = 2'b11
  } isiz_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2,
    ACK   = 2'd3
  } state_e;

  // All-zero word decodes as an illegal instruction, so a failed fetch traps the CPU.
  localparam logic [DAT_W-1:0] ILLEGAL_INSN = 32'h0000_0000;

  // True when a non-idle request can be issued on the bus as-is.
  function automatic logic fetch_legal(input logic [1:0] isiz, input logic [1:0] adr_lo);
    logic ok;
    ok = 1'b0;
    case (isiz)
      ISIZ_H:  ok = (adr_lo[0] == 1'b0);
      ISIZ_W:  ok = (adr_lo == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Beat watchdog: counts stalled cycles and flags when the last allowed one is reached.
module bus_watchdog #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam int unsigned  CW   = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Saturate at LAST so a stall that outlives the bridge reaction cannot wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q   <= '0;
      expired <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      expired <= (cnt_d == LAST);
    end
  end

endmodule

// File: rtl/polaris_ibus_bridge.sv
// Splits Polaris instruction fetches into little-endian 16-bit bus beats; failed
// fetches (misaligned, reserved size, timeout) return the illegal all-zero word.
module polaris_ibus_bridge
  import polaris_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [ADR_W-1:0]  iadr_i,
  input  logic [1:0]        isiz_i,
  output logic              iack_o,
  output logic [DAT_W-1:0]  idat_o,
  output logic              m_cyc_o,
  output logic              m_stb_o,
  output logic [ADR_W-1:0]  m_adr_o,
  input  logic [BEAT_W-1:0] m_dat_i,
  input  logic              m_ack_i,
  output logic              err_o
);

  state_e              state_q, state_d;
  logic                word_q, word_d;
  logic [BEAT_W-1:0]   lo_q, lo_d;
  logic                iack_d, err_d, cyc_d, stb_d;
  logic [DAT_W-1:0]    idat_d;
  logic [ADR_W-1:0]    adr_d;
  logic                in_beat_c;
  logic                wd_count_c;
  logic                wd_expired;

  assign in_beat_c  = (state_q == BEAT0) || (state_q == BEAT1);
  assign wd_count_c = in_beat_c && !m_ack_i;

  // Any acknowledged beat or non-beat cycle restarts the stall count.
  bus_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear   (!wd_count_c),
    .count   (wd_count_c),
    .expired (wd_expired)
  );

  // Next state and next registered outputs.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    lo_d    = lo_q;
    iack_d  = 1'b0;
    err_d   = 1'b0;
    idat_d  = '0;
    cyc_d   = 1'b0;
    stb_d   = 1'b0;
    adr_d   = '0;

    case (state_q)
      IDLE: begin
        if (isiz_i != ISIZ_NONE) begin
          if (fetch_legal(isiz_i, iadr_i[1:0])) begin
            state_d = BEAT0;
            word_d  = (isiz_i == ISIZ_W);
            cyc_d   = 1'b1;
            stb_d   = 1'b1;
            adr_d   = iadr_i;
          end else begin
            state_d = ACK;
            iack_d  = 1'b1;
            err_d   = 1'b1;
            idat_d  = ILLEGAL_INSN;
          end
        end
      end

      BEAT0, BEAT1: begin
        cyc_d = 1'b1;
        stb_d = 1'b1;
        adr_d = m_adr_o;
        if (m_ack_i) begin
          if ((state_q == BEAT0) && word_q) begin
            state_d = BEAT1;
            lo_d    = m_dat_i;
            adr_d   = m_adr_o + ADR_W'(2);
          end else begin
            state_d = ACK;
            iack_d  = 1'b1;
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
            adr_d   = '0;
            if (state_q == BEAT0) begin
              lo_d   = m_dat_i;
              idat_d = {BEAT_W'(0), m_dat_i};
            end else begin
              idat_d = {m_dat_i, lo_q};
            end
          end
        end else if (wd_expired) begin
          state_d = ACK;
          iack_d  = 1'b1;
          err_d   = 1'b1;
          idat_d  = ILLEGAL_INSN;
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          adr_d   = '0;
        end
      end

      ACK: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      word_q  <= 1'b0;
      lo_q    <= '0;
      iack_o  <= 1'b0;
      err_o   <= 1'b0;
      idat_o  <= '0;
      m_cyc_o <= 1'b0;
      m_stb_o <= 1'b0;
      m_adr_o <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      lo_q    <= lo_d;
      iack_o  <= iack_d;
      err_o   <= err_d;
      idat_o  <= idat_d;
      m_cyc_o <= cyc_d;
      m_stb_o <= stb_d;
      m_adr_o <= adr_d;
    end
  end

endmodule

// File: tb/tb_polaris_ibus_bridge.sv
// Directed and random fetches against a wait-state slave, checked with a latency/data model.
module tb_polaris_ibus_bridge;

  localparam int unsigned TO = 4;

  logic        clk_i;
  logic        reset_i;
  logic [63:0] iadr_i;
  logic [1:0]  isiz_i;
  logic        iack_o;
  logic [31:0] idat_o;
  logic        m_cyc_o;
  logic        m_stb_o;
  logic [63:0] m_adr_o;
  logic [15:0] m_dat_i;
  logic        m_ack_i;
  logic        err_o;

  int unsigned errors = 0;
  int unsigned checks = 0;

  int unsigned w0 = 0;
  int unsigned w1 = 0;
  logic        stray_ack = 1'b0;
  logic [7:0]  wcnt;
  logic        beat;

  polaris_ibus_bridge #(.TIMEOUT(TO)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .iadr_i  (iadr_i),
    .isiz_i  (isiz_i),
    .iack_o  (iack_o),
    .idat_o  (idat_o),
    .m_cyc_o (m_cyc_o),
    .m_stb_o (m_stb_o),
    .m_adr_o (m_adr_o),
    .m_dat_i (m_dat_i),
    .m_ack_i (m_ack_i),
    .err_o   (err_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Program memory contents seen by the slave.
  function automatic logic [15:0] mem(input logic [63:0] a);
    logic [15:0] d;
    case (a)
      64'hFFFF_FFFF_FFFF_FF00: d = 16'h0013;
      64'hFFFF_FFFF_FFFF_FF02: d = 16'h0000;
      64'h0000_0000_0000_0102: d = 16'hABCD;
      default:                 d = a[15:0] ^ a[47:32] ^ 16'h5A3C;
    endcase
    return d;
  endfunction

  // Slave: beat k is acknowledged once it has waited w0 (first beat) or w1 (second beat) cycles.
  always @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wcnt <= '0;
      beat <= 1'b0;
    end else begin
      if (!m_cyc_o)     beat <= 1'b0;
      else if (m_ack_i) beat <= 1'b1;
      if (m_stb_o && !m_ack_i && wcnt != 8'hFF) wcnt <= wcnt + 8'd1;
      else                                     wcnt <= '0;
    end
  end

  assign m_ack_i = (m_stb_o && (32'(wcnt) >= (beat ? w1 : w0))) || stray_ack;
  assign m_dat_i = mem(m_adr_o);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One fetch: request sampled at the next edge, then compare against the model.
  task automatic run_txn(input logic [63:0] a, input logic [1:0] sz,
                         input int unsigned x0, input int unsigned x1);
    logic        illegal;
    int unsigned e_lat;
    logic [31:0] e_dat;
    logic        e_err;
    logic [63:0] e_last;
    int unsigned lat, stbc;
    logic [31:0] g_dat;
    logic        g_err;
    logic [63:0] first_adr, last_adr;
    logic        idle_dat_bad;

    illegal = (sz == 2'b11) || (sz == 2'b10 && a[1:0] != 2'b00) || (sz == 2'b01 && a[0]);
    e_last  = a;
    if (illegal) begin
      e_lat = 1; e_dat = 32'h0; e_err = 1'b1;
    end else if (x0 >= TO) begin
      e_lat = 1 + TO; e_dat = 32'h0; e_err = 1'b1;
    end else if (sz == 2'b01) begin
      e_lat = 2 + x0; e_dat = {16'h0, mem(a)}; e_err = 1'b0;
    end else if (x1 >= TO) begin
      e_lat = 2 + x0 + TO; e_dat = 32'h0; e_err = 1'b1; e_last = a + 64'd2;
    end else begin
      e_lat = 3 + x0 + x1; e_dat = {mem(a + 64'd2), mem(a)}; e_err = 1'b0; e_last = a + 64'd2;
    end

    @(negedge clk_i);
    w0 = x0; w1 = x1;
    iadr_i = a; isiz_i = sz;
    @(posedge clk_i);
    #1;
    isiz_i = 2'b00;
    iadr_i = {$urandom, $urandom};
    lat = 0; stbc = 0; g_dat = '0; g_err = 1'b0;
    first_adr = '0; last_adr = '0; idle_dat_bad = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk_i);
      if (iack_o) begin
        lat = k; g_dat = idat_o; g_err = err_o;
        break;
      end
      if (idat_o != 32'h0) idle_dat_bad = 1'b1;
      if (m_stb_o) begin
        if (stbc == 0) first_adr = m_adr_o;
        last_adr = m_adr_o;
        stbc++;
      end
    end
    check("latency", 64'(lat), 64'(e_lat));
    check("idat", 64'(g_dat), 64'(e_dat));
    check("err", 64'(g_err), 64'(e_err));
    check("stb_cycles", 64'(stbc), 64'(e_lat - 1));
    check("idat_zero_while_waiting", 64'(idle_dat_bad), 64'h0);
    if (!illegal) begin
      check("first_adr", first_adr, a);
      check("last_adr", last_adr, e_last);
    end
    @(negedge clk_i);
    check("iack_one_cycle", 64'(iack_o), 64'h0);
    check("idat_after_ack", 64'(idat_o), 64'h0);
    check("cyc_after_ack", 64'(m_cyc_o), 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed=stuck expected=finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    logic [63:0] ra;
    logic [1:0]  rs;
    reset_i = 1'b1;
    iadr_i  = '0;
    isiz_i  = 2'b00;
    repeat (2) @(negedge clk_i);
    check("rst_iack", 64'(iack_o), 64'h0);
    check("rst_idat", 64'(idat_o), 64'h0);
    check("rst_cyc", 64'(m_cyc_o), 64'h0);
    check("rst_stb", 64'(m_stb_o), 64'h0);
    check("rst_adr", m_adr_o, 64'h0);
    check("rst_err", 64'(err_o), 64'h0);
    reset_i = 1'b0;

    // Reset while the second beat is stalled.
    @(negedge clk_i);
    w0 = 0; w1 = 200;
    iadr_i = 64'hFFFF_FFFF_FFFF_FF00; isiz_i = 2'b10;
    @(posedge clk_i);
    #1 isiz_i = 2'b00;
    repeat (2) @(negedge clk_i);
    check("beat1_stb", 64'(m_stb_o), 64'h1);
    check("beat1_adr", m_adr_o, 64'hFFFF_FFFF_FFFF_FF02);
    #2 reset_i = 1'b1;
    #1;
    check("async_rst_cyc", 64'(m_cyc_o), 64'h0);
    check("async_rst_stb", 64'(m_stb_o), 64'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      check("no_iack_in_rst", 64'(iack_o), 64'h0);
    end
    reset_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      check("no_iack_after_rst", 64'(iack_o), 64'h0);
      check("idle_after_rst", 64'(m_stb_o), 64'h0);
    end

    // Directed cases.
    run_txn(64'hFFFF_FFFF_FFFF_FF00, 2'b10, 0, 0);
    run_txn(64'hFFFF_FFFF_FFFF_FF00, 2'b10, 2, 2);
    run_txn(64'h0000_0000_0000_0102, 2'b01, 0, 0);
    run_txn(64'h0000_0000_0000_0102, 2'b10, 0, 0);
    run_txn(64'h0000_0000_0000_1000, 2'b11, 0, 0);
    run_txn(64'h0000_0000_0000_1001, 2'b01, 0, 0);
    run_txn(64'h0000_0000_0000_2000, 2'b10, 200, 0);
    run_txn(64'h0000_0000_0000_2004, 2'b10, 0, 0);
    run_txn(64'h0000_0000_0000_3000, 2'b10, 1, 200);
    run_txn(64'h0000_0000_0000_3008, 2'b10, 3, 3);
    run_txn(64'hFFFF_FFFF_FFFF_FFFC, 2'b10, 0, 1);
    run_txn(64'hFFFF_FFFF_FFFF_FFFE, 2'b01, 1, 0);

    // Stray acknowledge while idle must not start anything.
    @(negedge clk_i);
    stray_ack = 1'b1;
    @(negedge clk_i);
    stray_ack = 1'b0;
    check("stray_ack_iack", 64'(iack_o), 64'h0);
    check("stray_ack_stb", 64'(m_stb_o), 64'h0);
    run_txn(64'h0000_0000_0000_4000, 2'b01, 0, 0);

    // Random fetches, including misaligned sizes and timeouts on either beat.
    for (int n = 0; n < 40; n++) begin
      ra = {$urandom, $urandom};
      rs = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 3) != 0) ra[1:0] = (rs == 2'b01) ? {ra[1], 1'b0} : 2'b00;
      if (n % 8 == 0) ra[63:8] = '1;
      run_txn(ra, rs, $urandom_range(0, 5), $urandom_range(0, 5));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
